// File: rtl/sum_out_buffer.sv
// Output FIFO for the noise path: scales each adder2 sum by an arithmetic right
// shift, saturates it to 16 bits, buffers it with its clip flag and counts clips.
module sum_out_buffer #(
   parameter int DEPTH = 4,
   parameter int SHIFT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [21:0]              sum,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [15:0]              out_data,
   output logic                     out_sat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              sat_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   // Each entry holds {sat, data}.
   logic [16:0]       mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       level_reg;
   logic [15:0]       sat_count_reg;

   logic signed [21:0] scaled;
   logic [15:0]        sat_data;
   logic               sat_flag;
   logic               push;
   logic               pop;

   assign scaled = $signed(sum) >>> SHIFT;

   always_comb begin
      sat_data = scaled[15:0];
      sat_flag = 1'b0;
      if (scaled > 22'sd32767) begin
         sat_data = 16'h7FFF;
         sat_flag = 1'b1;
      end else if (scaled < -22'sd32768) begin
         sat_data = 16'h8000;
         sat_flag = 1'b1;
      end
   end

   assign in_ready  = (level_reg != LEVEL_FULL);
   assign out_valid = (level_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage has no reset; the empty-state mux below keeps stale words invisible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {sat_flag, sat_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         sat_count_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LEVEL_ONE;
            2'b01:   level_reg <= level_reg - LEVEL_ONE;
            default: level_reg <= level_reg;
         endcase
         if (push && sat_flag && (sat_count_reg != 16'hFFFF)) begin
            sat_count_reg <= sat_count_reg + 16'd1;
         end
      end
   end

   assign out_data  = out_valid ? mem[rd_ptr_reg][15:0] : 16'h0000;
   assign out_sat   = out_valid ? mem[rd_ptr_reg][16]   : 1'b0;
   assign level     = level_reg;
   assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_sum_out_buffer.sv
// Directed bench for sum_out_buffer: vector table for scaling/saturation/fill,
// plus hand sequences for streaming and asynchronous reset.
module tb_sum_out_buffer;

   logic        clk;
   logic        rst_n;
   logic [21:0] sum;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic [15:0] sat_count;

   int errors = 0;
   int checks = 0;

   sum_out_buffer #(.DEPTH(4), .SHIFT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sum       (sum),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .sat_count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        iv;
      logic [21:0] s;
      logic        ordy;
      logic        e_valid;
      logic [15:0] e_data;
      logic        e_sat;
      logic [2:0]  e_level;
      logic        e_in_ready;
      logic [15:0] e_sat_count;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic e_valid, input logic [15:0] e_data,
                          input logic e_sat, input logic [2:0] e_level, input logic e_in_ready,
                          input logic [15:0] e_sat_count);
      chk({name, ".out_valid"}, {15'd0, out_valid}, {15'd0, e_valid});
      chk({name, ".out_data"},  out_data, e_data);
      chk({name, ".out_sat"},   {15'd0, out_sat}, {15'd0, e_sat});
      chk({name, ".level"},     {13'd0, level}, {13'd0, e_level});
      chk({name, ".in_ready"},  {15'd0, in_ready}, {15'd0, e_in_ready});
      chk({name, ".sat_count"}, sat_count, e_sat_count);
      $display("%s: iv=%b sum=%h ordy=%b -> valid=%b data=%h sat=%b level=%0d rdy=%b cnt=%0d",
               name, in_valid, sum, out_ready, out_valid, out_data, out_sat, level, in_ready, sat_count);
   endtask

   task automatic add(input string name, input logic iv, input logic [21:0] s, input logic ordy,
                      input logic ev, input logic [15:0] ed, input logic es, input logic [2:0] el,
                      input logic er, input logic [15:0] ec);
      vec_t v;
      v.name = name; v.iv = iv; v.s = s; v.ordy = ordy;
      v.e_valid = ev; v.e_data = ed; v.e_sat = es; v.e_level = el;
      v.e_in_ready = er; v.e_sat_count = ec;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, clock it, then sample #1 after the edge.
   task automatic step(input logic iv, input logic [21:0] s, input logic ordy);
      in_valid  = iv;
      sum       = s;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          name      iv  sum         ordy  valid data      sat  lvl rdy cnt
      add("p100",     1, 22'h000100, 0, 1, 16'h0010, 0, 3'd1, 1, 16'd0);
      add("pop0",     0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd0);
      add("pmax",     1, 22'h1FFFFF, 0, 1, 16'h7FFF, 1, 3'd1, 1, 16'd1);
      add("pmin",     1, 22'h200000, 0, 1, 16'h7FFF, 1, 3'd2, 1, 16'd2);
      add("popmax",   0, 22'h000000, 1, 1, 16'h8000, 1, 3'd1, 1, 16'd2);
      add("popmin",   0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd2);
      add("pm1",      1, 22'h3FFFFF, 0, 1, 16'hFFFF, 0, 3'd1, 1, 16'd2);
      add("popm1",    0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd2);
      add("pm16",     1, 22'h3FFFF0, 0, 1, 16'hFFFF, 0, 3'd1, 1, 16'd2);
      add("popm16",   0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd2);
      add("p7fff",    1, 22'h07FFFF, 0, 1, 16'h7FFF, 0, 3'd1, 1, 16'd2);
      add("pop7fff",  0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd2);
      add("p8000",    1, 22'h080000, 0, 1, 16'h7FFF, 1, 3'd1, 1, 16'd3);
      add("pop8000",  0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd3);
      add("pneg",     1, 22'h380000, 0, 1, 16'h8000, 0, 3'd1, 1, 16'd3);
      add("popneg",   0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd3);
      add("pneg1",    1, 22'h37FFFF, 0, 1, 16'h8000, 1, 3'd1, 1, 16'd4);
      add("popneg1",  0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd4);
      add("emptypop", 0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd4);
      add("pm8",      1, 22'h3FFFF8, 0, 1, 16'hFFFF, 0, 3'd1, 1, 16'd4);
      add("popm8",    0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd4);
      add("ivlow",    0, 22'h1FFFFF, 0, 0, 16'h0000, 0, 3'd0, 1, 16'd4);
      // Fill to full with the consumer stalled, then drain.
      add("fill1",    1, 22'h000010, 0, 1, 16'h0001, 0, 3'd1, 1, 16'd4);
      add("fill2",    1, 22'h000020, 0, 1, 16'h0001, 0, 3'd2, 1, 16'd4);
      add("fill3",    1, 22'h000030, 0, 1, 16'h0001, 0, 3'd3, 1, 16'd4);
      add("fill4",    1, 22'h000040, 0, 1, 16'h0001, 0, 3'd4, 0, 16'd4);
      add("full5",    1, 22'h000050, 0, 1, 16'h0001, 0, 3'd4, 0, 16'd4);
      add("fullpop",  1, 22'h000050, 1, 1, 16'h0002, 0, 3'd3, 1, 16'd4);
      add("pushpop",  1, 22'h000050, 1, 1, 16'h0003, 0, 3'd3, 1, 16'd4);
      add("drain3",   0, 22'h000000, 1, 1, 16'h0004, 0, 3'd2, 1, 16'd4);
      add("drain4",   0, 22'h000000, 1, 1, 16'h0005, 0, 3'd1, 1, 16'd4);
      add("drain5",   0, 22'h000000, 1, 0, 16'h0000, 0, 3'd0, 1, 16'd4);

      rst_n = 1'b0; in_valid = 1'b0; sum = '0; out_ready = 1'b0;
      #1;
      chk_all("reset", 0, 16'h0000, 0, 3'd0, 1, 16'd0);
      #12 rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         step(vecs[i].iv, vecs[i].s, vecs[i].ordy);
         chk_all(vecs[i].name, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_sat,
                 vecs[i].e_level, vecs[i].e_in_ready, vecs[i].e_sat_count);
      end

      // Streaming: one sample in and one out per cycle, level pinned at 1.
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 22'((k + 1) << 4), 1'b1);
         chk($sformatf("stream%0d.level", k), {13'd0, level}, 16'd1);
         chk($sformatf("stream%0d.data", k), out_data, 16'(k + 1));
         $display("stream%0d: data=%h level=%0d", k, out_data, level);
      end
      step(1'b0, 22'h0, 1'b1);
      chk_all("streamend", 0, 16'h0000, 0, 3'd0, 1, 16'd4);

      // Asynchronous reset between edges with three entries buffered.
      step(1'b1, 22'h000070, 1'b0);
      step(1'b1, 22'h000080, 1'b0);
      step(1'b1, 22'h1FFFFF, 1'b0);
      chk_all("prerst", 1, 16'h0007, 0, 3'd3, 1, 16'd5);
      #2 rst_n = 1'b0;
      #1;
      chk_all("midrst", 0, 16'h0000, 0, 3'd0, 1, 16'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 22'h000100, 1'b0);
      chk_all("postrst", 1, 16'h0010, 0, 3'd1, 1, 16'd0);
      step(1'b0, 22'h0, 1'b1);
      chk_all("postrstpop", 0, 16'h0000, 0, 3'd0, 1, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sum_out_buffer.md
SUM_OUT_BUFFER -- requirements
Module: sum_out_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4: FIFO entries, power of two, at least 2.
REQ-002 The module SHALL have parameter SHIFT, default 4: arithmetic right-shift applied to each incoming sum, range 0..6.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port sum, input, 22 bits: signed two's-complement result from adder2.
REQ-006 The module SHALL have port in_valid, input, 1 bit: sum is valid this cycle.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the buffer can accept a sample.
REQ-008 The module SHALL have port out_data, output, 16 bits: signed, scaled and saturated noise sample.
REQ-009 The module SHALL have port out_sat, output, 1 bit: out_data was clipped.
REQ-010 The module SHALL have port out_valid, output, 1 bit: out_data and out_sat are valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the sample.
REQ-012 The module SHALL have port level, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 The module SHALL have port sat_count, output, 16 bits: running count of clipped samples.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal (level != DEPTH), combinational from registered state only; it SHALL have no path from out_ready.
REQ-016 out_valid SHALL equal (level != 0); out_data and out_sat SHALL be read from the head entry.
REQ-017 Scaling SHALL be s = sum >>> SHIFT (sign-extending arithmetic shift, rounding toward minus infinity).
REQ-018 Saturation: if s > 32767, store 16'h7FFF; if s < -32768, store 16'h8000; otherwise store s[15:0].
REQ-019 The sat bit SHALL be stored with the data, and SHALL be 1 only when clipping occurred.
REQ-020 Latency: an entry pushed at edge N SHALL be visible, with out_valid=1, after edge N when the FIFO was empty, i.e. 1 cycle.
REQ-021 Ordering SHALL be strict FIFO, with no drops and no duplicates.
REQ-022 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 Simultaneous push and pop (level between 1 and DEPTH-1) SHALL leave level unchanged.
REQ-024 Full: in_ready=0, and in_valid SHALL be ignored with no state change.
REQ-025 Empty: out_ready SHALL be ignored, with no pointer or level change.
REQ-026 Full with a pop in the same cycle: no push that cycle; level SHALL drop to DEPTH-1.
REQ-027 sat_count SHALL increment by 1 on each push whose sat bit is 1.
REQ-028 sat_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 sum SHALL be sampled only on a push edge; values while in_valid=0 or in_ready=0 SHALL have no effect.

Reset
REQ-030 When rst_n=0, asynchronously: pointers=0, level=0, sat_count=0, out_valid=0, in_ready=1, out_data=0, out_sat=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; no partial push or pop SHALL complete.
REQ-032 The first push SHALL be permitted on the first rising edge after rst_n is sampled high.
REQ-033 Memory contents need not be cleared, but out_data SHALL read 0 whenever level=0 after reset.

Verification
REQ-034 Push sum=22'h000100, out_ready=0 -> next cycle: out_valid=1, out_data=16'h0010, out_sat=0, level=1.
REQ-035 Push 22'h1FFFFF then 22'h200000 -> out_data=16'h7FFF then 16'h8000, both with out_sat=1, sat_count=2.
REQ-036 Push 22'h3FFFFF (-1) -> out_data=16'hFFFF, out_sat=0; push 22'h3FFFF0 (-16) -> 16'hFFFF.
REQ-037 Hold out_ready=0 and push 5 samples (1..5 <<4) -> in_ready=0 after the 4th push, and the 5th is held. Then out_ready=1 -> outputs 1,2,3,4,5 in order; the pointers wrap.
REQ-038 Run continuous in_valid=1, out_ready=1 for 20 cycles -> level stays 1 and throughput is 1 sample per cycle.
REQ-039 Assert rst_n=0 between clock edges while level=3 -> level=0, out_valid=0 and sat_count=0 immediately; after release, a new push produces the correct output.
